alu_seq: RTL
============

# alu_seq

Multi-cycle command sequencer wrapped around the 8-bit `alu`. It accepts one command at a time over a valid/ready handshake, captures the operands, and drives the single shared `alu` instance for one or more passes. It returns a result plus flags over a second valid/ready handshake. It adds shift-by-N and unsigned 8x8 multiply on top of the eight native ALU ops, and is the CPU execute stage's only path to the `alu`.

## Interface
- `MUL_EN`, default 1: 1 enables MUL; 0 decodes MUL as illegal.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: command present.
- `in_ready` out 1: sequencer can accept; equals (state == IDLE).
- `cmd` in 4: command. 0–7 are the native ALU ops (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR); 8 = SHLN; 9 = SHRN; 10 = MUL; 11–15 are illegal.
- `a`, `b` in 8 each: operands. For SHLN/SHRN the shift count k = `b[2:0]`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `res_lo` out 8: result, or product low byte for MUL.
- `res_hi` out 8: product high byte for MUL; 0 otherwise.
- `zero`, `carry`, `negative`, `overflow`, `err` out 1 each: result flags.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, ITER, DONE.
- Accept occurs on the edge where `in_valid && in_ready`. At that edge, `cmd`, `a` and `b` are captured into internal registers; input changes afterwards have no effect.
- **IDLE:** on accept, go to ITER with pass counter n = number of passes required.
- **Native ops (0–7):** n = 1. A single pass drives the captured operands and op to `alu`. All four flags are registered exactly as `alu` produces them.
- **SHLN / SHRN:** n = max(k, 1).
  - Each pass feeds the working value through `alu` SHL or SHR and writes it back.
  - `carry` = bit shifted out on the last pass.
  - k = 0: result = `a`, `carry` = 0, `overflow` = 0; `zero` and `negative` come from `a`.
  - `overflow` is always 0.
- **MUL (shift-add):** n = 8.
  - Registers: P (8b) = 0, M = `b`.
  - Each pass: if `M[0]`, `{c, P}` = `alu` ADD(P, `a`), else c = 0. Then `{c, P, M}` is shifted right by 1 inside the sequencer.
  - After 8 passes: `res_hi` = P, `res_lo` = M.
  - Flags: `zero` = ({P, M} == 0); `carry` = (P != 0); `negative` = `P[7]`; `overflow` = 0.
- **Illegal cmd (11–15, or 10 when `MUL_EN` = 0):** n = 1. Result 0, `zero` = 1, `err` = 1, all other flags 0.
- `err` = 0 for every legal command.
- **ITER:** decrement n on each pass; when n reaches 0, register the outputs and go to DONE.
- **DONE:** `out_valid` = 1 and all outputs are held stable until `out_ready`. On the `out_ready` edge, go to IDLE.
- No command overlap: a new accept is possible no earlier than the cycle after the output handshake.

## Timing
- Reset, asynchronous and taking effect at any time including mid-ITER or in DONE:
  - state goes to IDLE;
  - all registers go to 0;
  - `out_valid` = 0; all result and flag outputs = 0; `busy` = 0; `in_ready` = 1.
  - The in-flight command is discarded with no output.
- Latency, counting from the accept edge E0: `out_valid` rises after edge E_n, where n is the pass count defined above.
  - Native ops, illegal commands, and shifts with k ≤ 1: 1 cycle.
  - SHLN/SHRN with k ≥ 2: k cycles.
  - MUL: 8 cycles.
- Best-case throughput is one native op every 3 cycles: accept, then DONE + handshake, then IDLE.
- If `out_ready` is already high when DONE is entered, the handshake completes on the first DONE edge.
- `in_valid` asserted while busy is ignored; it is not latched.
- All outputs are registered; `in_ready` and `busy` are decoded from registered state.

## Structure
- Package `alu_pkg`:
  - 3-bit ALU op constants (ADD…SHR);
  - 4-bit `cmd` encodings (SHLN, SHRN, MUL, illegal range);
  - state enum (IDLE, ITER, DONE).
- Sub-module: exactly one `alu` instance. Its `a`, `b` and `op` inputs are muxed from the captured operands, P, and the working value. `alu` is not duplicated.
- Pass counter: 4 bits.

## Test plan
- ADD a=0x7F, b=0x01 -> `res_lo` = 0x80, `negative` = 1, `overflow` = 1, `carry` = 0, `zero` = 0, `out_valid` 1 cycle after accept.
- MUL a=0xFF, b=0xFF -> `res_hi` = 0xFE, `res_lo` = 0x01, `carry` = 1, `zero` = 0, `out_valid` 8 cycles after accept. Also MUL a=0x00, b=0x37 -> 0x0000 with `zero` = 1.
- SHLN a=0x81, b=3 -> `res_lo` = 0x08, `carry` = 0, 3 cycles. SHRN a=0x01, b=1 -> 0x00, `zero` = 1, `carry` = 1. SHLN b=0 -> `res_lo` = `a`, 1 cycle.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE -> outputs stable, `in_ready` = 0, pulsing `in_valid` is ignored. Raise `out_ready` -> `in_ready` = 1 on the next cycle.
- Assert `rst` during pass 4 of MUL -> `out_valid` = 0 immediately, no result ever emitted, `in_ready` = 1. A subsequent SUB a=0x05, b=0x03 returns 0x02.
- `cmd` = 0xC, and MUL with `MUL_EN` = 0 -> `err` = 1, `res_lo` = 0, `zero` = 1, 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: native ALU ops, extended
// command encodings, sequencer states and command decode helpers.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    localparam logic [3:0] CMD_SHLN   = 4'd8;
    localparam logic [3:0] CMD_SHRN   = 4'd9;
    localparam logic [3:0] CMD_MUL    = 4'd10;
    localparam logic [3:0] CMD_ILL_LO = 4'd11;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    typedef enum logic [1:0] {K_NATIVE, K_SHIFT, K_MUL, K_ILL} kind_t;

    function automatic kind_t decode_kind(input logic [3:0] cmd, input logic mul_en);
        kind_t k;
        if (cmd < CMD_SHLN)                         k = K_NATIVE;
        else if (cmd == CMD_SHLN || cmd == CMD_SHRN) k = K_SHIFT;
        else if (cmd == CMD_MUL && mul_en)           k = K_MUL;
        else                                         k = K_ILL;
        return k;
    endfunction

    // ALU op used on every pass of a command.
    function automatic logic [2:0] decode_op(input logic [3:0] cmd);
        logic [2:0] op;
        if (cmd < CMD_SHLN)       op = cmd[2:0];
        else if (cmd == CMD_SHLN) op = OP_SHL;
        else if (cmd == CMD_SHRN) op = OP_SHR;
        else                      op = OP_ADD;
        return op;
    endfunction

    function automatic logic [3:0] pass_count(input kind_t kind, input logic [2:0] k);
        logic [3:0] n;
        case (kind)
            K_SHIFT: n = (k > 3'd1) ? {1'b0, k} : 4'd1;
            K_MUL:   n = 4'd8;
            default: n = 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command and result handshakes between the execute stage and the ALU sequencer.
interface alu_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res_lo;
    logic [7:0] res_hi;
    logic       zero;
    logic       carry;
    logic       negative;
    logic       overflow;
    logic       err;
    logic       busy;

    modport master (
        output in_valid, cmd, a, b, out_ready,
        input  in_ready, out_valid, res_lo, res_hi, zero, carry, negative, overflow, err, busy
    );

    modport slave (
        input  in_valid, cmd, a, b, out_ready,
        output in_ready, out_valid, res_lo, res_hi, zero, carry, negative, overflow, err, busy
    );
endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU. SUB reports borrow (a < b) on carry; logic ops
// clear carry and overflow; single-bit shifts report the bit shifted out.
module alu
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] y,
    output logic       zero,
    output logic       carry,
    output logic       negative,
    output logic       overflow
);
    always_comb begin
        y        = 8'h00;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                {carry, y} = {1'b0, a} + {1'b0, b};
                overflow   = (a[7] == b[7]) && (y[7] != a[7]);
            end
            OP_SUB: begin
                {carry, y} = {1'b0, a} - {1'b0, b};
                overflow   = (a[7] != b[7]) && (y[7] != a[7]);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: {carry, y} = {a, 1'b0};
            OP_SHR: {y, carry} = {1'b0, a};
            default: ;
        endcase
        zero     = (y == 8'h00);
        negative = y[7];
    end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle command sequencer around a single shared ALU: native ops,
// multi-bit shifts and a shift-add 8x8 unsigned multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    state_t     state;
    kind_t      kind;
    kind_t      kind_in;
    logic [2:0] op;
    logic [3:0] cnt;
    logic [7:0] a_r, b_r, w_r, p_r;

    logic [7:0] alu_a, alu_b, alu_y;
    logic       alu_z, alu_c, alu_n, alu_v;

    logic       sh_skip, sh_c, mul_c;
    logic [7:0] sh_y, mul_p, p_nx, m_nx;

    // w_r is the shift working value, or the multiplier M during MUL.
    always_comb begin
        alu_a = a_r;
        alu_b = b_r;
        case (kind)
            K_SHIFT: alu_a = w_r;
            K_MUL: begin
                alu_a = p_r;
                alu_b = a_r;
            end
            default: ;
        endcase
    end

    alu u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .op       (op),
        .y        (alu_y),
        .zero     (alu_z),
        .carry    (alu_c),
        .negative (alu_n),
        .overflow (alu_v)
    );

    assign kind_in = decode_kind(bus.cmd, MUL_EN);

    assign sh_skip = (b_r[2:0] == 3'd0);
    assign sh_y    = sh_skip ? w_r : alu_y;
    assign sh_c    = !sh_skip && alu_c;

    assign mul_c = w_r[0] & alu_c;
    assign mul_p = w_r[0] ? alu_y : p_r;
    assign p_nx  = {mul_c, mul_p[7:1]};
    assign m_nx  = {mul_p[0], w_r[7:1]};

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            kind         <= K_NATIVE;
            op           <= OP_ADD;
            cnt          <= 4'd0;
            a_r          <= 8'h00;
            b_r          <= 8'h00;
            w_r          <= 8'h00;
            p_r          <= 8'h00;
            bus.out_valid <= 1'b0;
            bus.res_lo   <= 8'h00;
            bus.res_hi   <= 8'h00;
            bus.zero     <= 1'b0;
            bus.carry    <= 1'b0;
            bus.negative <= 1'b0;
            bus.overflow <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    kind  <= kind_in;
                    op    <= decode_op(bus.cmd);
                    cnt   <= pass_count(kind_in, bus.b[2:0]);
                    a_r   <= bus.a;
                    b_r   <= bus.b;
                    w_r   <= (kind_in == K_MUL) ? bus.b : bus.a;
                    p_r   <= 8'h00;
                    state <= ITER;
                end
                ITER: begin
                    cnt <= cnt - 4'd1;
                    case (kind)
                        K_SHIFT: w_r <= sh_y;
                        K_MUL: begin
                            p_r <= p_nx;
                            w_r <= m_nx;
                        end
                        default: ;
                    endcase
                    if (cnt == 4'd1) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.res_hi    <= 8'h00;
                        bus.overflow  <= 1'b0;
                        bus.err       <= 1'b0;
                        case (kind)
                            K_NATIVE: begin
                                bus.res_lo   <= alu_y;
                                bus.zero     <= alu_z;
                                bus.carry    <= alu_c;
                                bus.negative <= alu_n;
                                bus.overflow <= alu_v;
                            end
                            K_SHIFT: begin
                                bus.res_lo   <= sh_y;
                                bus.zero     <= (sh_y == 8'h00);
                                bus.carry    <= sh_c;
                                bus.negative <= sh_y[7];
                            end
                            K_MUL: begin
                                bus.res_lo   <= m_nx;
                                bus.res_hi   <= p_nx;
                                bus.zero     <= ({p_nx, m_nx} == 16'h0000);
                                bus.carry    <= (p_nx != 8'h00);
                                bus.negative <= p_nx[7];
                            end
                            default: begin
                                bus.res_lo   <= 8'h00;
                                bus.zero     <= 1'b1;
                                bus.carry    <= 1'b0;
                                bus.negative <= 1'b0;
                                bus.err      <= 1'b1;
                            end
                        endcase
                    end
                end
                DONE: if (bus.out_ready) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
